// File: rtl/chrono_bcd.sv
// chrono_bcd: MM:SS.cc BCD stopwatch driven by two raw pushbuttons.
// Key sync/debounce, run/pause/clear FSM, tick prescaler and digit cascade.

module chrono_key #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);
  localparam int DW = $clog2(DEB + 1);

  logic s1, s2, acc, acc_q;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      acc   <= 1'b1;
      acc_q <= 1'b1;
      cnt   <= '0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      acc_q <= acc;
      if (s2 == acc) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB - 1)) begin
        acc <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // releases are filtered too, but only the falling edge is an event
  assign press = acc_q & ~acc;
endmodule

module chrono_bcd #(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] cs0,
  output logic [3:0] cs1,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic       running,
  output logic       wrap
);
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t state, state_nx;
  logic start_p, clear_p, clr, tick;
  logic [PW-1:0] pre;
  logic c0, c1, c2, c3, c4, c5;

  chrono_key #(.DEB(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .reset_n(reset_n),
    .key_n(key_start_n), .press(start_p)
  );

  chrono_key #(.DEB(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .reset_n(reset_n),
    .key_n(key_clear_n), .press(clear_p)
  );

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    unique case (state)
      IDLE:  if (start_p) state_nx = RUN;
      RUN:   if (start_p) state_nx = PAUSE;
      PAUSE: begin
        if (clear_p) begin
          state_nx = IDLE;
          clr      = 1'b1;
        end else if (start_p) begin
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tick = (state == RUN) && (pre == PW'(DIV - 1));

  assign c0 = cs0 == 4'd9;
  assign c1 = c0 && cs1 == 4'd9;
  assign c2 = c1 && s0 == 4'd9;
  assign c3 = c2 && s1 == 4'd5;
  assign c4 = c3 && m0 == 4'd9;
  assign c5 = c4 && m1 == 4'd5;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      running <= 1'b0;
      wrap    <= 1'b0;
      pre     <= '0;
    end else begin
      state   <= state_nx;
      running <= state_nx == RUN;
      wrap    <= tick && c5;
      if (clr)
        pre <= '0;
      else if (state == RUN)
        pre <= tick ? '0 : pre + 1'b1;
    end
  end

  // enable-style updates: digits hold their value unless cleared or ticked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs0 <= '0; cs1 <= '0;
      s0  <= '0; s1  <= '0;
      m0  <= '0; m1  <= '0;
    end else if (clr) begin
      cs0 <= '0; cs1 <= '0;
      s0  <= '0; s1  <= '0;
      m0  <= '0; m1  <= '0;
    end else if (tick) begin
      cs0 <= c0 ? 4'd0 : cs0 + 4'd1;
      if (c0) cs1 <= c1 ? 4'd0 : cs1 + 4'd1;
      if (c1) s0  <= c2 ? 4'd0 : s0 + 4'd1;
      if (c2) s1  <= c3 ? 4'd0 : s1 + 4'd1;
      if (c3) m0  <= c4 ? 4'd0 : m0 + 4'd1;
      if (c4) m1  <= c5 ? 4'd0 : m1 + 4'd1;
    end
  end
endmodule
